// File: rtl/ega_video_tx.sv
// EGA/CGA TTL video source: 6-bit RGB, H/V sync, 200/350-line modes.
// Ports: clk, rst (sync high), pix_en, mode_sel, pix_in[5:0] in;
//        pix_x, pix_y, pix_act, frame_start, mode, R0..B1, H, V out.
// Optional: EGA_TX_PATTERN_EN replaces pix_in with colour bars.
module ega_video_tx #(
  parameter int H_ACT   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 160,
  parameter int V2_ACT  = 200,
  parameter int V2_FP   = 24,
  parameter int V2_SYNC = 3,
  parameter int V2_BP   = 35,
  parameter int V3_ACT  = 350,
  parameter int V3_FP   = 1,
  parameter int V3_SYNC = 2,
  parameter int V3_BP   = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  input  logic       mode_sel,
  input  logic [5:0] pix_in,
  output logic [9:0] pix_x,
  output logic [8:0] pix_y,
  output logic       pix_act,
  output logic       frame_start,
  output logic       mode,
  output logic       R0,
  output logic       R1,
  output logic       G0,
  output logic       G1,
  output logic       B0,
  output logic       B1,
  output logic       H,
  output logic       V
);

  localparam int H_TOT  = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V2_TOT = V2_ACT + V2_FP + V2_SYNC + V2_BP;
  localparam int V3_TOT = V3_ACT + V3_FP + V3_SYNC + V3_BP;

  generate
    if (H_TOT > 1024) begin : g_hchk
      $error("H_TOT exceeds 10-bit counter");
    end
    if (V2_TOT > 512 || V3_TOT > 512) begin : g_vchk
      $error("V_TOT exceeds 9-bit counter");
    end
  endgenerate

  localparam logic [9:0] HACT  = 10'(H_ACT);
  localparam logic [9:0] HS0   = 10'(H_ACT + H_FP);
  localparam logic [9:0] HS1   = 10'(H_ACT + H_FP + H_SYNC);
  localparam logic [9:0] HLAST = 10'(H_TOT - 1);

  logic [9:0] hx;
  logic [8:0] vy;
  logic [5:0] rgb;
  logic [8:0] vact, vs0, vs1, vlast;
  logic       hwrap, vwrap;
  logic       h_nxt, v_on, v_nxt;
  logic [5:0] px;

  always_comb begin
    vact  = mode ? 9'(V2_ACT) : 9'(V3_ACT);
    vs0   = mode ? 9'(V2_ACT + V2_FP) : 9'(V3_ACT + V3_FP);
    vs1   = mode ? 9'(V2_ACT + V2_FP + V2_SYNC)
                 : 9'(V3_ACT + V3_FP + V3_SYNC);
    vlast = mode ? 9'(V2_TOT - 1) : 9'(V3_TOT - 1);
  end

  assign hwrap = (hx >= HLAST);
  // >= also recovers a vy left out of range by a mode switch
  assign vwrap = (vy >= vlast);

  assign pix_x   = hx;
  assign pix_y   = vy;
  assign pix_act = (hx < HACT) && (vy < vact);

  assign frame_start = !rst && pix_en && (hx == '0) && (vy == '0);

  assign h_nxt = (hx >= HS0) && (hx < HS1);
  assign v_on  = (vy >= vs0) && (vy < vs1);
  assign v_nxt = mode ? v_on : !v_on;

`ifdef EGA_TX_PATTERN_EN
  logic [2:0] bar;

  // bar index from comparators at multiples of H_ACT/8
  always_comb begin
    bar = '0;
    for (int k = 1; k < 8; k++) begin
      if (hx >= 10'(k * H_ACT / 8)) bar = bar + 3'd1;
    end
    if (vy == '0) px = 6'h3F;
    else px = {bar[2], bar[2], bar[1], bar[1], bar[0], bar[0]};
  end
`else
  assign px = pix_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      hx   <= '0;
      vy   <= '0;
      mode <= 1'b0;
      rgb  <= '0;
      H    <= 1'b0;
      V    <= 1'b1;
    end else if (pix_en) begin
      hx <= hwrap ? '0 : hx + 10'd1;
      if (hwrap) begin
        vy <= vwrap ? '0 : vy + 9'd1;
        if (vwrap) mode <= mode_sel;
      end
      rgb <= pix_act ? px : '0;
      H   <= h_nxt;
      V   <= v_nxt;
    end
  end

  assign {R1, R0, G1, G0, B1, B0} = rgb;

endmodule
